// File: rtl/exu_ctl_pkg.sv
// Shared types and constants for the EXU issue/handoff controller.
package exu_ctl_pkg;

  localparam int PERF_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } exu_ctl_state_e;

endpackage

// File: rtl/exu_ctl_perf.sv
// Performance counter bank for exu_ctl: issues, LSU stalls and IFU flushes.
// Counters wrap naturally at 2^PERF_CNT_WIDTH.
module exu_ctl_perf
  import exu_ctl_pkg::*;
(
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic                      i_issue,
  input  logic                      i_stall,
  input  logic                      i_flush,
  output logic [PERF_CNT_WIDTH-1:0] o_issue_cnt,
  output logic [PERF_CNT_WIDTH-1:0] o_stall_cnt,
  output logic [PERF_CNT_WIDTH-1:0] o_flush_cnt
);

  logic [PERF_CNT_WIDTH-1:0] r_issue_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_stall_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_flush_cnt;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_issue_cnt <= r_issue_cnt + PERF_CNT_WIDTH'(i_issue);
      r_stall_cnt <= r_stall_cnt + PERF_CNT_WIDTH'(i_stall);
      r_flush_cnt <= r_flush_cnt + PERF_CNT_WIDTH'(i_flush);
    end
  end

  assign o_issue_cnt = r_issue_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/exu_ctl.sv
// EXU controller: accepts an IDU bundle, lets the EXU datapath compute for one
// cycle, then holds the result for the LSU. Optional counters: EXU_CTL_PERF_EN.
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 5
`endif

module exu_ctl
  import exu_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_idu_valid,
  output logic                   o_idu_ready,
  input  logic [DATA_WIDTH-1:0]  i_idu_pc,
  input  logic [`ARGS_WIDTH-1:0] i_idu_alu_type,
  input  logic [DATA_WIDTH-1:0]  i_idu_rs1_data,
  input  logic [DATA_WIDTH-1:0]  i_idu_rs2_data,
  input  logic [`ARGS_WIDTH-1:0] i_idu_jmp_type,
  input  logic [DATA_WIDTH-1:0]  i_idu_jmp_or_reg_data,
  output logic [DATA_WIDTH-1:0]  o_exu_pc,
  output logic [`ARGS_WIDTH-1:0] o_exu_alu_type,
  output logic [DATA_WIDTH-1:0]  o_exu_rs1_data,
  output logic [DATA_WIDTH-1:0]  o_exu_rs2_data,
  output logic [`ARGS_WIDTH-1:0] o_exu_jmp_type,
  output logic [DATA_WIDTH-1:0]  o_exu_jmp_or_reg_data,
  input  logic [DATA_WIDTH-1:0]  i_exu_res,
  input  logic                   i_exu_jmp_en,
  input  logic [DATA_WIDTH-1:0]  i_exu_jmp_pc,
  output logic                   o_lsu_valid,
  input  logic                   i_lsu_ready,
  output logic [DATA_WIDTH-1:0]  o_lsu_res,
  output logic [DATA_WIDTH-1:0]  o_lsu_pc,
  output logic                   o_ifu_jmp_en,
  output logic [DATA_WIDTH-1:0]  o_ifu_jmp_pc
`ifdef EXU_CTL_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] o_perf_issue_cnt,
  output logic [PERF_CNT_WIDTH-1:0] o_perf_stall_cnt,
  output logic [PERF_CNT_WIDTH-1:0] o_perf_flush_cnt
`endif
);

  exu_ctl_state_e r_state;
  exu_ctl_state_e w_state_nxt;

  logic w_accept;
  logic w_idu_ready;
  logic w_lsu_valid;

  logic [DATA_WIDTH-1:0]  r_exu_pc;
  logic [`ARGS_WIDTH-1:0] r_exu_alu_type;
  logic [DATA_WIDTH-1:0]  r_exu_rs1_data;
  logic [DATA_WIDTH-1:0]  r_exu_rs2_data;
  logic [`ARGS_WIDTH-1:0] r_exu_jmp_type;
  logic [DATA_WIDTH-1:0]  r_exu_jmp_or_reg_data;
  logic [DATA_WIDTH-1:0]  r_lsu_res;
  logic [DATA_WIDTH-1:0]  r_lsu_pc;
  logic                   r_ifu_jmp_en;
  logic [DATA_WIDTH-1:0]  r_ifu_jmp_pc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // NOTE: defaults first, so no path through the case leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = HOLD;
      HOLD:    if (i_lsu_ready) w_state_nxt = w_accept ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is withheld during the redirect cycle so the wrong-path offer is dropped.
  always_comb begin
    w_lsu_valid = (r_state == HOLD);
    w_idu_ready = (r_state == IDLE) |
                  ((r_state == HOLD) & i_lsu_ready & ~r_ifu_jmp_en);
  end

  assign w_accept = i_idu_valid & w_idu_ready;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_exu_pc              <= '0;
      r_exu_alu_type        <= '0;
      r_exu_rs1_data        <= '0;
      r_exu_rs2_data        <= '0;
      r_exu_jmp_type        <= '0;
      r_exu_jmp_or_reg_data <= '0;
      r_lsu_res             <= '0;
      r_lsu_pc              <= '0;
      r_ifu_jmp_en          <= 1'b0;
      r_ifu_jmp_pc          <= '0;
    end else begin
      if (w_accept) begin
        r_exu_pc              <= i_idu_pc;
        r_exu_alu_type        <= i_idu_alu_type;
        r_exu_rs1_data        <= i_idu_rs1_data;
        r_exu_rs2_data        <= i_idu_rs2_data;
        r_exu_jmp_type        <= i_idu_jmp_type;
        r_exu_jmp_or_reg_data <= i_idu_jmp_or_reg_data;
      end
      if (r_state == EXEC) begin
        r_lsu_res    <= i_exu_res;
        r_lsu_pc     <= r_exu_pc;
        r_ifu_jmp_pc <= i_exu_jmp_pc;
      end
      // Set only on the EXEC->HOLD edge, so the redirect is a single-cycle pulse.
      r_ifu_jmp_en <= (r_state == EXEC) & i_exu_jmp_en;
    end
  end

  assign o_idu_ready           = w_idu_ready;
  assign o_lsu_valid           = w_lsu_valid;
  assign o_exu_pc              = r_exu_pc;
  assign o_exu_alu_type        = r_exu_alu_type;
  assign o_exu_rs1_data        = r_exu_rs1_data;
  assign o_exu_rs2_data        = r_exu_rs2_data;
  assign o_exu_jmp_type        = r_exu_jmp_type;
  assign o_exu_jmp_or_reg_data = r_exu_jmp_or_reg_data;
  assign o_lsu_res             = r_lsu_res;
  assign o_lsu_pc              = r_lsu_pc;
  assign o_ifu_jmp_en          = r_ifu_jmp_en;
  assign o_ifu_jmp_pc          = r_ifu_jmp_pc;

`ifdef EXU_CTL_PERF_EN
  exu_ctl_perf u_perf (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst   (i_sys_rst),
    .i_issue     (w_accept),
    .i_stall     ((r_state == HOLD) & ~i_lsu_ready),
    .i_flush     (r_ifu_jmp_en),
    .o_issue_cnt (o_perf_issue_cnt),
    .o_stall_cnt (o_perf_stall_cnt),
    .o_flush_cnt (o_perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_exu_ctl.sv
// Directed bench for exu_ctl: vector table plus backpressure, jump, back-to-back
// and mid-HOLD reset sequences. Counter checks apply when EXU_CTL_PERF_EN is set.
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 5
`endif

module tb_exu_ctl;

  localparam int DW = 32;
  localparam logic [`ARGS_WIDTH-1:0] ALU_TYPE_ADD = 5'd1;
  localparam logic [`ARGS_WIDTH-1:0] ALU_TYPE_SUB = 5'd2;
  localparam logic [`ARGS_WIDTH-1:0] ALU_TYPE_XOR = 5'd3;
  localparam logic [`ARGS_WIDTH-1:0] ALU_TYPE_OR  = 5'd4;
  localparam logic [`ARGS_WIDTH-1:0] ALU_TYPE_AND = 5'd5;
  localparam logic [`ARGS_WIDTH-1:0] JMP_NONE     = 5'd0;
  localparam logic [`ARGS_WIDTH-1:0] JMP_J        = 5'd1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   idu_valid = 1'b0;
  logic                   idu_ready;
  logic [DW-1:0]          idu_pc = '0, idu_rs1 = '0, idu_rs2 = '0, idu_jr = '0;
  logic [`ARGS_WIDTH-1:0] idu_alu = '0, idu_jmp = '0;
  logic [DW-1:0]          exu_pc, exu_rs1, exu_rs2, exu_jr;
  logic [`ARGS_WIDTH-1:0] exu_alu, exu_jmp;
  logic [DW-1:0]          exu_res, exu_jmp_pc;
  logic                   exu_jmp_en;
  logic                   lsu_valid;
  logic                   lsu_ready = 1'b0;
  logic [DW-1:0]          lsu_res, lsu_pc;
  logic                   ifu_jmp_en;
  logic [DW-1:0]          ifu_jmp_pc;
`ifdef EXU_CTL_PERF_EN
  logic [31:0] perf_issue, perf_stall, perf_flush;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int exp_issue = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  exu_ctl #(.DATA_WIDTH(DW)) dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_idu_valid           (idu_valid),
    .o_idu_ready           (idu_ready),
    .i_idu_pc              (idu_pc),
    .i_idu_alu_type        (idu_alu),
    .i_idu_rs1_data        (idu_rs1),
    .i_idu_rs2_data        (idu_rs2),
    .i_idu_jmp_type        (idu_jmp),
    .i_idu_jmp_or_reg_data (idu_jr),
    .o_exu_pc              (exu_pc),
    .o_exu_alu_type        (exu_alu),
    .o_exu_rs1_data        (exu_rs1),
    .o_exu_rs2_data        (exu_rs2),
    .o_exu_jmp_type        (exu_jmp),
    .o_exu_jmp_or_reg_data (exu_jr),
    .i_exu_res             (exu_res),
    .i_exu_jmp_en          (exu_jmp_en),
    .i_exu_jmp_pc          (exu_jmp_pc),
    .o_lsu_valid           (lsu_valid),
    .i_lsu_ready           (lsu_ready),
    .o_lsu_res             (lsu_res),
    .o_lsu_pc              (lsu_pc),
    .o_ifu_jmp_en          (ifu_jmp_en),
    .o_ifu_jmp_pc          (ifu_jmp_pc)
`ifdef EXU_CTL_PERF_EN
    ,
    .o_perf_issue_cnt      (perf_issue),
    .o_perf_stall_cnt      (perf_stall),
    .o_perf_flush_cnt      (perf_flush)
`endif
  );

  // Stand-in EXU datapath driven from the controller's registered bundle.
  always_comb begin
    exu_res = '0;
    case (exu_alu)
      ALU_TYPE_ADD: exu_res = exu_rs1 + exu_rs2;
      ALU_TYPE_SUB: exu_res = exu_rs1 - exu_rs2;
      ALU_TYPE_XOR: exu_res = exu_rs1 ^ exu_rs2;
      ALU_TYPE_OR:  exu_res = exu_rs1 | exu_rs2;
      ALU_TYPE_AND: exu_res = exu_rs1 & exu_rs2;
      default:      exu_res = '0;
    endcase
    exu_jmp_en = (exu_jmp == JMP_J);
    exu_jmp_pc = exu_jr;
  end

  typedef struct {
    logic [`ARGS_WIDTH-1:0] alu;
    logic [`ARGS_WIDTH-1:0] jmp;
    logic [DW-1:0]          pc;
    logic [DW-1:0]          rs1;
    logic [DW-1:0]          rs2;
    logic [DW-1:0]          jr;
    logic [DW-1:0]          exp_res;
    logic                   exp_jen;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input vec_t v);
    idu_valid = 1'b1;
    idu_alu   = v.alu;
    idu_jmp   = v.jmp;
    idu_pc    = v.pc;
    idu_rs1   = v.rs1;
    idu_rs2   = v.rs2;
    idu_jr    = v.jr;
  endtask

  task automatic check_perf(input string tag);
`ifdef EXU_CTL_PERF_EN
    check({tag, "_issue_cnt"}, 64'(perf_issue), 64'(exp_issue));
    check({tag, "_stall_cnt"}, 64'(perf_stall), 64'(exp_stall));
    check({tag, "_flush_cnt"}, 64'(perf_flush), 64'(exp_flush));
`else
    n_cmp = n_cmp + 0;
`endif
  endtask

  // One complete operation from IDLE with i_lsu_ready held high.
  task automatic run_vec(input vec_t v, input string tag);
    lsu_ready = 1'b1;
    check({tag, "_idle_ready"}, 64'(idu_ready), 64'd1);
    offer(v);
    tick();
    exp_issue++;
    idu_valid = 1'b0;
    check({tag, "_exu_pc"}, 64'(exu_pc), 64'(v.pc));
    check({tag, "_exu_rs1"}, 64'(exu_rs1), 64'(v.rs1));
    check({tag, "_exu_rs2"}, 64'(exu_rs2), 64'(v.rs2));
    check({tag, "_exu_alu"}, 64'(exu_alu), 64'(v.alu));
    check({tag, "_exec_lsu_valid"}, 64'(lsu_valid), 64'd0);
    tick();
    check({tag, "_hold_lsu_valid"}, 64'(lsu_valid), 64'd1);
    check({tag, "_lsu_res"}, 64'(lsu_res), 64'(v.exp_res));
    check({tag, "_lsu_pc"}, 64'(lsu_pc), 64'(v.pc));
    check({tag, "_jmp_en"}, 64'(ifu_jmp_en), 64'(v.exp_jen));
    check({tag, "_hold_ready"}, 64'(idu_ready), 64'(!v.exp_jen));
    if (v.exp_jen) begin
      check({tag, "_jmp_pc"}, 64'(ifu_jmp_pc), 64'(v.jr));
      exp_flush++;
    end
    tick();
    check({tag, "_done_lsu_valid"}, 64'(lsu_valid), 64'd0);
    check({tag, "_done_jmp_en"}, 64'(ifu_jmp_en), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp, jv, rv;
    vec_t b2b[4];

    vecs[0] = '{ALU_TYPE_ADD, JMP_NONE, 32'h8000_0000, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0};
    vecs[1] = '{ALU_TYPE_XOR, JMP_NONE, 32'h8000_0004, 32'hFF00_FF00, 32'h0FF0_0FF0,
                32'd0, 32'hF0F0_F0F0, 1'b0};
    vecs[2] = '{ALU_TYPE_SUB, JMP_NONE, 32'h8000_0008, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{ALU_TYPE_ADD, JMP_J, 32'h8000_000C, 32'h8000_000C, 32'd4,
                32'h8000_0003, 32'h8000_0010, 1'b1};

    // Reset state, checked while reset is still asserted.
    #1;
    check("rst_lsu_valid", 64'(lsu_valid), 64'd0);
    check("rst_jmp_en", 64'(ifu_jmp_en), 64'd0);
    check("rst_exu_pc", 64'(exu_pc), 64'd0);
    check("rst_lsu_res", 64'(lsu_res), 64'd0);
    check("rst_idu_ready", 64'(idu_ready), 64'd1);
    check_perf("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check_perf("table");

    // Backpressure: three HOLD cycles with i_lsu_ready low.
    bp = '{ALU_TYPE_OR, JMP_NONE, 32'h8000_0100, 32'h0000_00F0, 32'h0000_000F,
           32'd0, 32'h0000_00FF, 1'b0};
    lsu_ready = 1'b0;
    offer(bp);
    tick();
    exp_issue++;
    idu_valid = 1'b0;
    idu_rs1   = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_lsu_valid", i), 64'(lsu_valid), 64'd1);
      check($sformatf("bp%0d_lsu_res", i), 64'(lsu_res), 64'h0000_00FF);
      check($sformatf("bp%0d_idu_ready", i), 64'(idu_ready), 64'd0);
      check($sformatf("bp%0d_exu_rs1_hold", i), 64'(exu_rs1), 64'h0000_00F0);
      tick();
      exp_stall++;
    end
    lsu_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(idu_ready), 64'd1);
    check("bp_release_res", 64'(lsu_res), 64'h0000_00FF);
    tick();
    check("bp_done_lsu_valid", 64'(lsu_valid), 64'd0);
    check_perf("bp");

    // Jump under backpressure: the redirect must pulse once only.
    jv = '{ALU_TYPE_ADD, JMP_J, 32'h8000_0200, 32'h8000_0200, 32'd4,
           32'h8000_0003, 32'h8000_0204, 1'b1};
    lsu_ready = 1'b0;
    offer(jv);
    tick();
    exp_issue++;
    idu_valid = 1'b0;
    tick();
    check("jbp_pulse", 64'(ifu_jmp_en), 64'd1);
    check("jbp_pc", 64'(ifu_jmp_pc), 64'h8000_0003);
    exp_flush++;
    tick();
    exp_stall++;
    check("jbp_no_repulse1", 64'(ifu_jmp_en), 64'd0);
    check("jbp_valid1", 64'(lsu_valid), 64'd1);
    tick();
    exp_stall++;
    check("jbp_no_repulse2", 64'(ifu_jmp_en), 64'd0);
    lsu_ready = 1'b1;
    #1;
    check("jbp_release_ready", 64'(idu_ready), 64'd1);
    tick();
    check("jbp_done_lsu_valid", 64'(lsu_valid), 64'd0);
    check_perf("jbp");

    // Back-to-back: handoff and next accept share an edge.
    b2b[0] = '{ALU_TYPE_SUB, JMP_NONE, 32'h8000_0300, 32'd10, 32'd3, 32'd0, 32'd7, 1'b0};
    b2b[1] = '{ALU_TYPE_XOR, JMP_NONE, 32'h8000_0304, 32'hA, 32'h5, 32'd0, 32'hF, 1'b0};
    b2b[2] = '{ALU_TYPE_OR, JMP_NONE, 32'h8000_0308, 32'h100, 32'h001, 32'd0, 32'h101, 1'b0};
    b2b[3] = '{ALU_TYPE_AND, JMP_NONE, 32'h8000_030C, 32'hFF0, 32'h0FF, 32'd0, 32'h0F0, 1'b0};
    lsu_ready = 1'b1;
    offer(b2b[0]);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("b2b%0d_ready", k), 64'(idu_ready), 64'd1);
      tick();
      exp_issue++;
      check($sformatf("b2b%0d_exec_pc", k), 64'(exu_pc), 64'(b2b[k].pc));
      check($sformatf("b2b%0d_exec_valid", k), 64'(lsu_valid), 64'd0);
      if (k < 3) offer(b2b[k + 1]);
      else       idu_valid = 1'b0;
      tick();
      check($sformatf("b2b%0d_valid", k), 64'(lsu_valid), 64'd1);
      check($sformatf("b2b%0d_res", k), 64'(lsu_res), 64'(b2b[k].exp_res));
      check($sformatf("b2b%0d_pc", k), 64'(lsu_pc), 64'(b2b[k].pc));
    end
    tick();
    check("b2b_done_lsu_valid", 64'(lsu_valid), 64'd0);
    check_perf("b2b");

    // Asynchronous reset in the middle of HOLD.
    rv = '{ALU_TYPE_ADD, JMP_NONE, 32'h8000_0400, 32'd5, 32'd6, 32'd0, 32'd11, 1'b0};
    lsu_ready = 1'b0;
    offer(rv);
    tick();
    idu_valid = 1'b0;
    tick();
    check("mrst_pre_valid", 64'(lsu_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_issue = 0;
    exp_stall = 0;
    exp_flush = 0;
    check("mrst_lsu_valid", 64'(lsu_valid), 64'd0);
    check("mrst_lsu_res", 64'(lsu_res), 64'd0);
    check("mrst_lsu_pc", 64'(lsu_pc), 64'd0);
    check("mrst_exu_pc", 64'(exu_pc), 64'd0);
    check("mrst_exu_rs1", 64'(exu_rs1), 64'd0);
    check("mrst_jmp_pc", 64'(ifu_jmp_pc), 64'd0);
    check("mrst_idu_ready", 64'(idu_ready), 64'd1);
    check_perf("mrst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    lsu_ready = 1'b1;
    #1;
    check("mrst_release_ready", 64'(idu_ready), 64'd1);
    tick();
    check("mrst_no_handoff", 64'(lsu_valid), 64'd0);
    run_vec(vecs[0], "post_rst");
    check_perf("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_ctl.md
EXU_CTL -- requirements
Module: exu_ctl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, which sets the width of the operand, PC and result datapaths.
REQ-002 SHALL have port i_sys_clk, input, 1 bit: the single clock. All logic is rising-edge.
REQ-003 SHALL have port i_sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have these IDU-side ports:
- i_idu_valid, input, 1 bit: IDU offer valid.
- o_idu_ready, output, 1 bit: controller can accept.
REQ-005 SHALL have these IDU bundle inputs, all captured on an accept:
- i_idu_pc, i_idu_rs1_data, i_idu_rs2_data, i_idu_jmp_or_reg_data: DATA_WIDTH each.
- i_idu_alu_type, i_idu_jmp_type: `ARGS_WIDTH each.
REQ-006 SHALL have registered outputs to the EXU datapath, each the same width as its IDU counterpart: o_exu_pc, o_exu_alu_type, o_exu_rs1_data, o_exu_rs2_data, o_exu_jmp_type, o_exu_jmp_or_reg_data.
REQ-007 SHALL have these inputs from the EXU datapath:
- i_exu_res: DATA_WIDTH.
- i_exu_jmp_en: 1 bit.
- i_exu_jmp_pc: DATA_WIDTH.
REQ-008 SHALL have these LSU-side ports:
- o_lsu_valid, output, 1 bit.
- i_lsu_ready, input, 1 bit.
- o_lsu_res, output, DATA_WIDTH.
- o_lsu_pc, output, DATA_WIDTH.
REQ-009 SHALL have these IFU redirect outputs: o_ifu_jmp_en (1 bit) and o_ifu_jmp_pc (DATA_WIDTH).

Function
REQ-010 SHALL implement a three-state FSM with states IDLE, EXEC and HOLD.
REQ-011 An accept SHALL occur when i_idu_valid and o_idu_ready are both high; the bundle is then registered onto the o_exu_* outputs and the next state is EXEC.
REQ-012 In EXEC (one cycle), SHALL capture i_exu_res, i_exu_jmp_en and i_exu_jmp_pc at the clock edge; the next state is always HOLD.
REQ-013 In HOLD, o_lsu_valid SHALL be 1, and o_lsu_res and o_lsu_pc SHALL stay stable until i_lsu_ready is sampled high.
REQ-014 In HOLD with i_lsu_ready=1, SHALL go to EXEC if an accept occurs in the same cycle, otherwise to IDLE.
REQ-015 o_idu_ready SHALL equal (state==IDLE) | (state==HOLD & i_lsu_ready & ~o_ifu_jmp_en).
REQ-016 Latency SHALL be: accept at edge N, o_lsu_valid high from cycle N+2; peak throughput is one operation per 2 cycles.
REQ-017 If the captured jmp_en=1, o_ifu_jmp_en SHALL pulse for exactly the first HOLD cycle, with o_ifu_jmp_pc set to the captured jump PC; it does not re-pulse while HOLD persists.
REQ-018 During the redirect cycle, o_idu_ready SHALL be 0 (wrong-path flush); the IDU drops its current offer.
REQ-019 The o_exu_* registers SHALL hold their values in HOLD and IDLE and change only on an accept.
REQ-020 Simultaneous i_lsu_ready and i_idu_valid in HOLD SHALL complete the handoff and the accept in the same edge, with no bubble.

Reset
REQ-021 On i_sys_rst=1, the state SHALL go to IDLE immediately, regardless of the clock.
REQ-022 On i_sys_rst=1, all registered outputs SHALL be 0: o_lsu_valid, o_ifu_jmp_en, every o_exu_*, o_lsu_res/pc and o_ifu_jmp_pc.
REQ-023 Reset mid-operation (EXEC or HOLD) SHALL discard the in-flight operation with no LSU handoff; o_idu_ready is 1 in the first cycle after reset release.

Configuration
REQ-024 With EXU_CTL_PERF_EN defined, SHALL add three 32-bit outputs:
- o_perf_issue_cnt: increments per accept.
- o_perf_stall_cnt: increments per HOLD cycle with i_lsu_ready=0.
- o_perf_flush_cnt: increments per o_ifu_jmp_en pulse.
REQ-025 The performance counters SHALL wrap at 2^32 and reset to 0.
REQ-026 Without EXU_CTL_PERF_EN, the counter ports and logic SHALL be absent and the remaining behaviour identical.

Structure
REQ-027 The state enum (exu_ctl_state_e: IDLE, EXEC, HOLD) and the PERF_CNT_WIDTH=32 constant SHALL live in the shared package; ALU/JMP type codes remain in cfg.sv.
REQ-028 The counter bank SHALL be the sub-module exu_ctl_perf, instantiated only under EXU_CTL_PERF_EN; the exu datapath is instantiated outside, beside exu_ctl.

Verification
REQ-029 Basic op: accept ALU_TYPE_ADD, rs1=1, rs2=2, pc=0x8000_0000, with the bench EXU returning 3. Required response: o_lsu_valid=1 two edges later with o_lsu_res=3 and o_lsu_pc=0x8000_0000.
REQ-030 Backpressure: i_lsu_ready=0 for 3 HOLD cycles. Required response: o_lsu_res stable, o_idu_ready=0 for those cycles, o_perf_stall_cnt=3.
REQ-031 Jump: JMP_J with i_exu_jmp_en=1 and i_exu_jmp_pc=0x8000_0003. Required response: o_ifu_jmp_en high for exactly 1 cycle with o_ifu_jmp_pc=0x8000_0003; o_idu_ready=0 in that cycle; o_perf_flush_cnt=1.
REQ-032 Back-to-back: 4 ops (SUB, XOR, OR, AND) offered continuously with i_lsu_ready=1. Required response: handoffs on every 2nd cycle, o_perf_issue_cnt=4, no bubble between handoff and accept.
REQ-033 Reset mid-HOLD: assert i_sys_rst for one cycle while o_lsu_valid=1. Required response: all outputs 0 asynchronously, state IDLE, o_idu_ready=1 after release.
REQ-034 Compile the bench without EXU_CTL_PERF_EN and rerun REQ-029 to REQ-033. Required response: functional results identical.
